// File: rtl/npc_pkg.sv
// Shared definitions for the npc load/store unit: access size codes, FSM
// states and the byte-enable helper.
package npc_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  // (2^(2^size) - 1) << off, computed on an 8-lane word and trimmed by the caller.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane steering for the LSU: store lane placement and mask, load
// extraction with sign/zero extension, and natural-alignment check.
module npc_lsu_align
  import npc_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  input  logic [OFFW-1:0] off_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [NB-1:0]   wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ldata_o,
  output logic            misalign_o
);

  logic [7:0]             mask8;
  logic [XLEN-1:0]        wsh;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        kept;
  logic signed [XLEN-1:0] kept_s;
  logic [6:0]             lsh;

  assign mask8   = byte_mask(size_i, 3'(off_i));
  assign wmask_o = mask8[NB-1:0];
  assign wsh     = wdata_i << {off_i, 3'b000};
  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      wdata_o[8*i +: 8] = wmask_o[i] ? wsh[8*i +: 8] : 8'h00;
    end
  end

  // Push the kept field to the top of the word, then shift back down
  // arithmetically or logically to extend it.
  always_comb begin
    case (size_i)
      SZ_B:    lsh = 7'(XLEN - 8);
      SZ_H:    lsh = 7'(XLEN - 16);
      SZ_W:    lsh = 7'(XLEN - 32);
      default: lsh = 7'd0;
    endcase
  end

  assign kept   = shifted << lsh;
  assign kept_s = kept;

  always_comb begin
    if (uns_i) ldata_o = kept >> lsh;
    else       ldata_o = kept_s >>> lsh;
  end

  always_comb begin
    case (size_i)
      SZ_H:    misalign_o = off_i[0];
      SZ_W:    misalign_o = |off_i[1:0];
      SZ_D:    misalign_o = |off_i;
      default: misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_lsu.sv
// Load/store unit: one outstanding access, registered valid/ready memory bus
// and a registered writeback response channel.
module npc_lsu
  import npc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_wb,
  output logic [4:0]          rsp_rd,
  output logic [XLEN-1:0]     rsp_data,
  output logic                rsp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e        state_q;
  logic              wen_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [OFFW-1:0]   off_q;
  logic              mem_req_valid_q;
  logic              mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [NB-1:0]     mem_wmask_q;
  logic              rsp_valid_q;
  logic              rsp_wb_q;
  logic [4:0]        rsp_rd_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_err_q;

  logic [1:0]        al_size;
  logic              al_uns;
  logic [OFFW-1:0]   al_off;
  logic [NB-1:0]     al_wmask;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_ldata;
  logic              al_misalign;
  logic              illegal;

  // The single aligner sees the incoming request while idle and the
  // latched request while a load response is being collected.
  always_comb begin
    if (state_q == S_IDLE) begin
      al_size = req_size;
      al_uns  = req_unsigned;
      al_off  = req_addr[OFFW-1:0];
    end else begin
      al_size = size_q;
      al_uns  = uns_q;
      al_off  = off_q;
    end
  end

  npc_lsu_align #(.XLEN(XLEN)) u_align (
    .size_i     (al_size),
    .uns_i      (al_uns),
    .off_i      (al_off),
    .rdata_i    (mem_rdata),
    .wdata_i    (req_wdata),
    .wmask_o    (al_wmask),
    .wdata_o    (al_wdata),
    .ldata_o    (al_ldata),
    .misalign_o (al_misalign)
  );

  assign illegal = (XLEN == 32) && (req_size == SZ_D);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wen_q           <= 1'b0;
      uns_q           <= 1'b0;
      size_q          <= 2'd0;
      off_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_wen_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_wb_q        <= 1'b0;
      rsp_rd_q        <= 5'd0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            wen_q    <= req_wen;
            uns_q    <= req_unsigned;
            size_q   <= req_size;
            off_q    <= req_addr[OFFW-1:0];
            rsp_rd_q <= req_rd;
            if (illegal || al_misalign) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_wb_q    <= 1'b0;
              rsp_data_q  <= '0;
              state_q     <= S_RESP;
            end else begin
              mem_req_valid_q <= 1'b1;
              mem_wen_q       <= req_wen;
              mem_addr_q      <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
              mem_wmask_q     <= req_wen ? al_wmask : '0;
              mem_wdata_q     <= req_wen ? al_wdata : '0;
              state_q         <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_wb_q    <= !wen_q && (rsp_rd_q != 5'd0);
            rsp_data_q  <= wen_q ? '0 : al_ldata;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_wb_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = mem_req_valid_q;
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_wb        = rsp_wb_q;
  assign rsp_rd        = rsp_rd_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

  // A bus response arriving while no load/store is waiting is a protocol error.
  assert property (@(posedge clk) disable iff (reset) mem_rsp_valid |-> state_q == S_WAIT)
    else $error("npc_lsu: mem_rsp_valid while not waiting for a response");

endmodule
